mem_ctrl: RTL and testbench

- Memory controller directly downstream of the MEM stage. It consumes the MEM stage's ram_* request (read / byte / half / word write) and also serves instruction-fetch requests.
- Serialises every access onto a byte-wide external RAM bus with one-cycle read latency.
- Returns assembled read words to the MEM stage and the fetch unit through busy/done handshakes.

---
 rtl/mem_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises MEM-stage data accesses (word read, byte/half/word
// write) and instruction fetches onto a byte-wide external RAM whose read data
// arrives one cycle after the address.
// Optional feature macro: MEMCTRL_DABORT_EN. When defined, a data request
// seen while a fetch is running aborts the fetch and is accepted at once.
//
// Handshake: ram_r_enable / ram_w_enable / if_req are level requests. They are
// sampled only in IDLE (data requests also in FETCH when MEMCTRL_DABORT_EN is
// defined); the request fields are latched at the accepting edge and ignored
// afterwards. Completion is a one-cycle ram_done / if_done pulse with the read
// data valid in that same cycle; the requester drops its request on seeing it.
// The FSM state and byte counter live together in the fsm struct.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_r_enable,
  input  logic              ram_w_enable,
  input  logic [31:0]       ram_addr,
  input  logic [31:0]       ram_w_data,
  input  logic [1:0]        ram_mask,
  output logic              ram_busy,
  output logic              ram_done,
  output logic [31:0]       ram_r_data,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DREAD  = 3'd1,
    DWRITE = 3'd2,
    FETCH  = 3'd3,
    DDONE  = 3'd4,
    FDONE  = 3'd5
  } state_t;

  // cnt counts edges since acceptance (1 right after the accepting edge)
  typedef struct packed {
    state_t     state;
    logic [2:0] cnt;
  } fsm_t;

  fsm_t              fsm;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        nbytes_q;
  logic [23:0]       rbuf;
  logic [2:0]        w_nbytes;
  logic              take_data;

  // Decode the write size from the mask: 0, 1, 2 or 4 bytes
  always_comb begin
    w_nbytes = 3'd0;
    case (ram_mask)
      2'b01:   w_nbytes = 3'd1;
      2'b10:   w_nbytes = 3'd2;
      2'b11:   w_nbytes = 3'd4;
      default: w_nbytes = 3'd0;
    endcase
  end

  // A data request is taken in IDLE, and optionally by aborting a fetch
  always_comb begin
    take_data = 1'b0;
    if (fsm.state == IDLE) begin
      take_data = ram_w_enable | ram_r_enable;
    end
`ifdef MEMCTRL_DABORT_EN
    else if (fsm.state == FETCH) begin
      take_data = ram_w_enable | ram_r_enable;
    end
`endif
  end

  // Main FSM: arbitration, byte serialisation and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm        <= '{state: IDLE, cnt: 3'd0};
      addr_q     <= '0;
      wdata_q    <= '0;
      nbytes_q   <= '0;
      rbuf       <= '0;
      ram_busy   <= 1'b0;
      ram_done   <= 1'b0;
      ram_r_data <= '0;
      if_done    <= 1'b0;
      if_data    <= '0;
      mem_dout   <= '0;
      mem_a      <= '0;
      mem_wr     <= 1'b0;
    end else begin
      ram_done <= 1'b0;
      if_done  <= 1'b0;
      mem_wr   <= 1'b0;
      if (take_data) begin
        // Write beats read; any partial fetch is simply dropped
        addr_q   <= ram_addr[ADDR_W-1:0];
        fsm.cnt  <= 3'd1;
        ram_busy <= 1'b1;
        if (ram_w_enable) begin
          fsm.state <= DWRITE;
          wdata_q   <= ram_w_data;
          nbytes_q  <= w_nbytes;
          if (w_nbytes != 3'd0) begin
            mem_wr   <= 1'b1;
            mem_a    <= ram_addr[ADDR_W-1:0];
            mem_dout <= ram_w_data[7:0];
          end
        end else begin
          fsm.state <= DREAD;
          mem_a     <= ram_addr[ADDR_W-1:0];
        end
      end else begin
        case (fsm.state)
          IDLE: begin
            if (if_req) begin
              fsm.state <= FETCH;
              fsm.cnt   <= 3'd1;
              addr_q    <= if_addr[ADDR_W-1:0];
              mem_a     <= if_addr[ADDR_W-1:0];
            end
          end
          DREAD, FETCH: begin
            // Address i goes out after edge i; its byte lands two edges later
            if (fsm.cnt <= 3'd3) begin
              mem_a <= addr_q + ADDR_W'(fsm.cnt);
            end
            case (fsm.cnt)
              3'd2:    rbuf[7:0]   <= mem_din;
              3'd3:    rbuf[15:8]  <= mem_din;
              3'd4:    rbuf[23:16] <= mem_din;
              default: ;
            endcase
            if (fsm.cnt == 3'd5) begin
              if (fsm.state == DREAD) begin
                fsm.state  <= DDONE;
                ram_r_data <= {mem_din, rbuf};
                ram_done   <= 1'b1;
                ram_busy   <= 1'b0;
              end else begin
                fsm.state <= FDONE;
                if_data   <= {mem_din, rbuf};
                if_done   <= 1'b1;
              end
            end
            fsm.cnt <= fsm.cnt + 3'd1;
          end
          DWRITE: begin
            if (fsm.cnt >= nbytes_q) begin
              fsm.state <= DDONE;
              ram_done  <= 1'b1;
              ram_busy  <= 1'b0;
            end else begin
              mem_wr   <= 1'b1;
              mem_a    <= addr_q + ADDR_W'(fsm.cnt);
              mem_dout <= wdata_q[{fsm.cnt[1:0], 3'b000} +: 8];
              fsm.cnt  <= fsm.cnt + 3'd1;
            end
          end
          DDONE, FDONE: begin
            fsm.state <= IDLE;
            fsm.cnt   <= 3'd0;
          end
          default: begin
            fsm.state <= IDLE;
            fsm.cnt   <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized and directed stimulus for mem_ctrl (ADDR_W=17)
// checked every cycle against a transaction-level timeline model.
module tb_mem_ctrl;

  localparam int AW   = 17;
  localparam int MEMN = 1 << AW;
  localparam int MAXC = 16384;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst;
  logic          ram_r_enable, ram_w_enable;
  logic [31:0]   ram_addr, ram_w_data;
  logic [1:0]    ram_mask;
  logic          ram_busy, ram_done;
  logic [31:0]   ram_r_data;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_done;
  logic [31:0]   if_data;
  logic [7:0]    mem_din, mem_dout;
  logic [AW-1:0] mem_a;
  logic          mem_wr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .ram_r_enable(ram_r_enable), .ram_w_enable(ram_w_enable),
    .ram_addr(ram_addr), .ram_w_data(ram_w_data), .ram_mask(ram_mask),
    .ram_busy(ram_busy), .ram_done(ram_done), .ram_r_data(ram_r_data),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  // ---------------- external RAM (one-cycle read latency) ----------------
  logic [7:0] phys   [0:MEMN-1];
  logic [7:0] shadow [0:MEMN-1];

  always @(posedge clk) begin
    if (mem_wr) phys[mem_a] = mem_dout;
    mem_din <= phys[mem_a];
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, edge_n);
    end
  endtask

  // ---------------- reference model: per-cycle expectation timeline ----------------
  // Cycle c is the interval following rising edge c.
  bit            ev_a_set [MAXC];
  logic [AW-1:0] ev_a     [MAXC];
  bit            ev_do_set[MAXC];
  logic [7:0]    ev_do    [MAXC];
  bit            ev_wr    [MAXC];
  bit            ev_busy  [MAXC];
  bit            ev_rdone [MAXC];
  bit            ev_idone [MAXC];
  bit            ev_rd_set[MAXC];
  logic [31:0]   ev_rd    [MAXC];
  bit            ev_if_set[MAXC];
  logic [31:0]   ev_if    [MAXC];

  int free_at = 0;     // first edge at which a new request can be accepted
  int fetch_t = -100;  // accepting edge of the current fetch

  task automatic clear_from(input int a, input int b);
    for (int c = a; c <= b; c++) begin
      ev_a_set[c] = 1'b0; ev_do_set[c] = 1'b0; ev_wr[c] = 1'b0; ev_busy[c] = 1'b0;
      ev_rdone[c] = 1'b0; ev_idone[c] = 1'b0; ev_rd_set[c] = 1'b0; ev_if_set[c] = 1'b0;
    end
  endtask

  // A 4-byte read: address i on the bus in cycle t+i, word returned in cycle t+5
  task automatic sched_read(input int t, input logic [AW-1:0] addr, input bit is_fetch);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      ev_a_set[t+i] = 1'b1;
      ev_a[t+i]     = addr + AW'(i);
      w[8*i +: 8]   = shadow[addr + AW'(i)];
    end
    if (is_fetch) begin
      ev_idone[t+5] = 1'b1; ev_if_set[t+5] = 1'b1; ev_if[t+5] = w;
    end else begin
      for (int c = t; c < t + 5; c++) ev_busy[c] = 1'b1;
      ev_rdone[t+5] = 1'b1; ev_rd_set[t+5] = 1'b1; ev_rd[t+5] = w;
    end
  endtask

  // An N-byte write: byte i driven in cycle t+i, done in cycle t+max(N,1)
  task automatic sched_write(input int t, input logic [AW-1:0] addr, input logic [31:0] wd,
                             input logic [1:0] mask, output int next_free);
    int n;
    int dur;
    n   = (mask == 2'b01) ? 1 : (mask == 2'b10) ? 2 : (mask == 2'b11) ? 4 : 0;
    dur = (n == 0) ? 1 : n;
    for (int i = 0; i < n; i++) begin
      ev_a_set[t+i]  = 1'b1;
      ev_a[t+i]      = addr + AW'(i);
      ev_do_set[t+i] = 1'b1;
      ev_do[t+i]     = wd[8*i +: 8];
      ev_wr[t+i]     = 1'b1;
      shadow[addr + AW'(i)] = wd[8*i +: 8];
    end
    for (int c = t; c < t + dur; c++) ev_busy[c] = 1'b1;
    ev_rdone[t+dur] = 1'b1;
    next_free = t + dur + 2;
  endtask

  // Model: arbitration at each rising edge, expressed as accept times
  always @(posedge clk) begin
    int nf;
    edge_n = edge_n + 1;
    if (!rst) begin
      clear_from(edge_n, edge_n + 8);
      free_at = 0;
      fetch_t = -100;
    end else begin
`ifdef MEMCTRL_DABORT_EN
      if ((ram_r_enable || ram_w_enable) && edge_n > fetch_t && edge_n <= fetch_t + 5) begin
        clear_from(edge_n, fetch_t + 6);
        fetch_t = -100;
        free_at = edge_n;
      end
`endif
      if (edge_n >= free_at) begin
        if (ram_w_enable) begin
          sched_write(edge_n, ram_addr[AW-1:0], ram_w_data, ram_mask, nf);
          free_at = nf;
        end else if (ram_r_enable) begin
          sched_read(edge_n, ram_addr[AW-1:0], 1'b0);
          free_at = edge_n + 7;
        end else if (if_req) begin
          sched_read(edge_n, if_addr[AW-1:0], 1'b1);
          fetch_t = edge_n;
          free_at = edge_n + 7;
        end
      end
    end
  end

  // Compare process: every output checked on the falling edge of every cycle
  logic [AW-1:0] cur_a;
  logic [7:0]    cur_do;
  logic [31:0]   cur_rd, cur_if;
  bit            e_wr, e_busy, e_rdone, e_idone;

  always @(negedge clk) begin
    if (!rst) begin
      cur_a = '0; cur_do = '0; cur_rd = '0; cur_if = '0;
      e_wr = 1'b0; e_busy = 1'b0; e_rdone = 1'b0; e_idone = 1'b0;
    end else begin
      if (ev_a_set[edge_n])  cur_a  = ev_a[edge_n];
      if (ev_do_set[edge_n]) cur_do = ev_do[edge_n];
      if (ev_rd_set[edge_n]) cur_rd = ev_rd[edge_n];
      if (ev_if_set[edge_n]) cur_if = ev_if[edge_n];
      e_wr    = ev_wr[edge_n];
      e_busy  = ev_busy[edge_n];
      e_rdone = ev_rdone[edge_n];
      e_idone = ev_idone[edge_n];
    end
    chk("mem_a",      32'(mem_a),   32'(cur_a));
    chk("mem_dout",   32'(mem_dout), 32'(cur_do));
    chk("mem_wr",     32'(mem_wr),  32'(e_wr));
    chk("ram_busy",   32'(ram_busy), 32'(e_busy));
    chk("ram_done",   32'(ram_done), 32'(e_rdone));
    chk("ram_r_data", ram_r_data,   cur_rd);
    chk("if_done",    32'(if_done), 32'(e_idone));
    chk("if_data",    if_data,      cur_if);
  end

  // ---------------- driver tasks ----------------
  logic [AW-1:0] a_trace [4];

  task automatic put_byte(input logic [AW-1:0] a, input logic [7:0] v);
    phys[a]   = v;
    shadow[a] = v;
  endtask

  // MEM-stage request held until ram_done; k = edge count at raise, d = done cycle
  task automatic data_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] mask, output int k, output int d);
    int n;
    @(posedge clk); #2;
    ram_addr = addr; ram_w_data = wd; ram_mask = mask;
    ram_w_enable = wr; ram_r_enable = !wr;
    k = edge_n; d = -1; n = 0;
    while (d < 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (edge_n - k >= 1 && edge_n - k <= 4) a_trace[edge_n-k-1] = mem_a;
      if (ram_done) d = edge_n;
    end
    ram_w_enable = 1'b0; ram_r_enable = 1'b0;
    if (d < 0) begin
      n_checks++; n_fail++;
      $display("FAIL data_timeout: got no ram_done in 60 cycles, expected one");
    end
  endtask

  // Fetch request held until if_done
  task automatic fetch_req(input logic [31:0] addr, output int k, output int d);
    int n;
    @(posedge clk); #2;
    if_addr = addr; if_req = 1'b1;
    k = edge_n; d = -1; n = 0;
    while (d < 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (if_done) d = edge_n;
    end
    if_req = 1'b0;
    if (d < 0) begin
      n_checks++; n_fail++;
      $display("FAIL fetch_timeout: got no if_done in 60 cycles, expected one");
    end
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int dk, dd, fk, fd, dly, kind;
    logic [7:0] saved;
    logic [31:0] ra, rd;
    bit wr;
    ram_r_enable = 1'b0; ram_w_enable = 1'b0; ram_addr = '0; ram_w_data = '0;
    ram_mask = 2'b00; if_req = 1'b0; if_addr = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < MEMN; i++) put_byte(AW'(i), 8'($urandom));
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("reset_busy",   32'(ram_busy), 32'd0);
    chk("reset_r_data", ram_r_data, 32'd0);

    // word read
    put_byte(17'h100, 8'hEF); put_byte(17'h101, 8'hBE);
    put_byte(17'h102, 8'hAD); put_byte(17'h103, 8'hDE);
    data_req(1'b0, 32'h100, 32'h0, 2'b00, dk, dd);
    chk("read_latency", dd - dk - 1, 32'd5);
    chk("read_word",    ram_r_data, 32'hDEADBEEF);
    chk("read_a0", 32'(a_trace[0]), 32'h100);
    chk("read_a3", 32'(a_trace[3]), 32'h103);

    // stores
    data_req(1'b1, 32'h203, 32'h000000AA, 2'b01, dk, dd);
    chk("sb_latency", dd - dk - 1, 32'd1);
    chk("sb_byte", 32'(phys[17'h203]), 32'hAA);
    data_req(1'b1, 32'h204, 32'h00001234, 2'b10, dk, dd);
    chk("sh_latency", dd - dk - 1, 32'd2);
    chk("sh_byte0", 32'(phys[17'h204]), 32'h34);
    chk("sh_byte1", 32'(phys[17'h205]), 32'h12);
    saved = phys[17'h208];
    data_req(1'b1, 32'h208, 32'hFFFFFFFF, 2'b00, dk, dd);
    chk("nop_latency", dd - dk - 1, 32'd1);
    chk("nop_untouched", 32'(phys[17'h208]), 32'(saved));
    data_req(1'b1, 32'h300, 32'hCAFEF00D, 2'b11, dk, dd);
    chk("sw_latency", dd - dk - 1, 32'd4);
    data_req(1'b0, 32'h300, 32'h0, 2'b00, dk, dd);
    chk("sw_readback", ram_r_data, 32'hCAFEF00D);

    // arbitration: data and fetch raised together
    put_byte(17'h400, 8'hDF); put_byte(17'h401, 8'h9B);
    put_byte(17'h402, 8'h57); put_byte(17'h403, 8'h13);
    fork
      fetch_req(32'h400, fk, fd);
      data_req(1'b0, 32'h100, 32'h0, 2'b00, dk, dd);
    join
    chk("arb_rdone", dd - dk, 32'd6);
    chk("arb_idone", fd - fk, 32'd13);
    chk("arb_if_data", if_data, 32'h13579BDF);

    // data read raised one cycle into a fetch
    fork
      fetch_req(32'h400, fk, fd);
      begin
        @(posedge clk);
        data_req(1'b0, 32'h300, 32'h0, 2'b00, dk, dd);
      end
    join
`ifdef MEMCTRL_DABORT_EN
    chk("abort_rdone", dd - fk, 32'd7);
    chk("abort_idone", fd - fk, 32'd14);
`else
    chk("noabort_idone", fd - fk, 32'd6);
    chk("noabort_rdone", dd - fk, 32'd13);
`endif
    chk("abort_if_data", if_data, 32'h13579BDF);
    chk("abort_r_data",  ram_r_data, 32'hCAFEF00D);

    // asynchronous reset in the middle of a word read
    @(posedge clk); #2;
    ram_addr = 32'h100; ram_r_enable = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    ram_r_enable = 1'b0;
    #1;
    chk("rst_mid_busy",   32'(ram_busy), 32'd0);
    chk("rst_mid_mem_a",  32'(mem_a), 32'd0);
    chk("rst_mid_r_data", ram_r_data, 32'd0);
    chk("rst_mid_if_data", if_data, 32'd0);
    chk("rst_mid_dout",   32'(mem_dout), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_done", 32'(ram_done), 32'd0);
    end
    @(posedge clk); #2 rst = 1'b1;
    data_req(1'b0, 32'h100, 32'h0, 2'b00, dk, dd);
    chk("post_rst_latency", dd - dk - 1, 32'd5);
    chk("post_rst_word", ram_r_data, 32'hDEADBEEF);

    // address wrap at 2^17
    put_byte(17'h1FFFE, 8'h11); put_byte(17'h1FFFF, 8'h22);
    put_byte(17'h00000, 8'h33); put_byte(17'h00001, 8'h44);
    data_req(1'b0, 32'h0001FFFE, 32'h0, 2'b00, dk, dd);
    chk("wrap_a0", 32'(a_trace[0]), 32'h1FFFE);
    chk("wrap_a1", 32'(a_trace[1]), 32'h1FFFF);
    chk("wrap_a2", 32'(a_trace[2]), 32'h00000);
    chk("wrap_a3", 32'(a_trace[3]), 32'h00001);
    chk("wrap_word", ram_r_data, 32'h44332211);

    // randomized traffic
    for (int it = 0; it < 120; it++) begin
      kind = $urandom_range(0, 3);
      wr   = 1'($urandom_range(0, 1));
      ra   = $urandom;
      rd   = $urandom;
      case (kind)
        0: data_req(1'b1, ra, rd, 2'($urandom_range(0, 3)), dk, dd);
        1: data_req(1'b0, ra, rd, 2'b00, dk, dd);
        2: fetch_req($urandom, fk, fd);
        default: begin
          dly = $urandom_range(0, 8);
          fork
            fetch_req($urandom, fk, fd);
            begin
              repeat (dly) @(posedge clk);
              data_req(wr, ra, rd, 2'($urandom_range(0, 3)), dk, dd);
            end
          join
        end
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #(MAXC * 10 - 100);
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to have ended", edge_n);
    $fatal(1);
  end

endmodule
